// File: rtl/bit_stream_deserializer.sv
// Purpose: gathers a valid-qualified serial bit stream into WIDTH-bit words, zero-padding early-terminated words.
// Latency: data_val_o pulses one cycle after the cycle that accepted the completing bit; one bit per cycle sustained.
// Backpressure: none; the downstream popcount always accepts, so every completed word is emitted unconditionally.
module bit_stream_deserializer #(
    parameter int WIDTH     = 24,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic                     ser_data_i,
    input  logic                     ser_data_val_i,
    input  logic                     ser_last_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(WIDTH):0]   data_len_o,
    output logic                     data_val_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int LW = CW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    // cnt doubles as the implicit state: zero means idle, non-zero means mid-word
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] col;

    logic [CW-1:0]    bit_pos;
    logic [WIDTH-1:0] col_next;
    logic [LW-1:0]    len_next;
    logic             word_done;

    // First bit lands at the top for MSB-first framing, at the bottom otherwise
    assign bit_pos = MSB_FIRST ? (LAST_IDX - cnt) : cnt;

    // A word closes on the WIDTH-th bit or on a sender-marked last bit, never twice
    assign word_done = ser_data_val_i && ((cnt == LAST_IDX) || ser_last_i);

    // Word length is the bit count including the bit accepted this cycle
    assign len_next = {1'b0, cnt} + LW'(1);

    // Merge the incoming bit into the collect register; untouched positions stay zero
    always_comb begin
        col_next          = col;
        col_next[bit_pos] = ser_data_i;
    end

    // Collect bits and publish a complete word with a single-cycle valid pulse
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt        <= '0;
            col        <= '0;
            data_o     <= '0;
            data_len_o <= '0;
            data_val_o <= 1'b0;
        end else begin
            data_val_o <= 1'b0;
            if (ser_data_val_i) begin
                if (word_done) begin
                    data_o     <= col_next;
                    data_len_o <= len_next;
                    data_val_o <= 1'b1;
                    cnt        <= '0;
                    col        <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                    col <= col_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_stream_deserializer.sv
// Bench for bit_stream_deserializer: three instances (8 MSB-first, 8 LSB-first, 24 MSB-first) share one stream.
// A word-level reference model predicts every cycle's outputs; directed cases add fixed expected constants.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_bit_stream_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n;
    logic sd, sv, sl;

    logic [7:0]  d8m_data, d8l_data;
    logic [3:0]  d8m_len,  d8l_len;
    logic        d8m_val,  d8l_val;
    logic [23:0] d24_data;
    logic [4:0]  d24_len_lo;
    logic [5:0]  d24_len;
    logic        d24_val;

    bit_stream_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_d8m (
        .clk_i(clk), .arst_n_i(arst_n), .ser_data_i(sd), .ser_data_val_i(sv), .ser_last_i(sl),
        .data_o(d8m_data), .data_len_o(d8m_len), .data_val_o(d8m_val));

    bit_stream_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_d8l (
        .clk_i(clk), .arst_n_i(arst_n), .ser_data_i(sd), .ser_data_val_i(sv), .ser_last_i(sl),
        .data_o(d8l_data), .data_len_o(d8l_len), .data_val_o(d8l_val));

    bit_stream_deserializer #(.WIDTH(24), .MSB_FIRST(1'b1)) u_d24 (
        .clk_i(clk), .arst_n_i(arst_n), .ser_data_i(sd), .ser_data_val_i(sv), .ser_last_i(sl),
        .data_o(d24_data), .data_len_o(d24_len), .data_val_o(d24_val));

    assign d24_len_lo = d24_len[4:0];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: received bits kept in arrival order, word built only when it closes
    int          W [3] = '{8, 8, 24};
    bit          M [3] = '{1'b1, 1'b0, 1'b1};
    int          n [3];
    logic [63:0] seq [3];
    logic [63:0] exp_data [3];
    int          exp_len [3];
    bit          exp_val [3];

    function automatic logic [63:0] build(int k);
        logic [63:0] w = '0;
        for (int i = 0; i < n[k]; i++) begin
            if (M[k]) w[W[k] - 1 - i] = seq[k][i];
            else      w[i]            = seq[k][i];
        end
        return w;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            n[k] = 0; seq[k] = '0;
            exp_data[k] = '0; exp_len[k] = 0; exp_val[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic v, input logic d, input logic l);
        exp_val[k] = 1'b0;
        if (v) begin
            seq[k][n[k]] = d;
            n[k]++;
            if (n[k] == W[k] || l) begin
                exp_data[k] = build(k);
                exp_len[k]  = n[k];
                exp_val[k]  = 1'b1;
                n[k]        = 0;
                seq[k]      = '0;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model to match
    task automatic cyc(input logic v, input logic d, input logic l);
        sv = v; sd = d; sl = l;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, v, d, l);
        #1;
    endtask

    task automatic do_reset();
        sv = 1'b0; sd = 1'b0; sl = 1'b0;
        arst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_val",  64'(d8m_val),  64'd0);
        chk("rst_data", 64'(d24_data), 64'd0);
        chk("rst_len",  64'(d8l_len),  64'd0);
        repeat (3) @(posedge clk);
        #2;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Every falling edge: all three instances against the model
    bit mon_en = 1'b0;
    int d24_pulses = 0;

    task automatic mon_one(input int k, input string tag, input logic [63:0] dat,
                           input logic [63:0] len, input logic val);
        chk({tag, "_val"},  64'(val), 64'(exp_val[k]));
        chk({tag, "_data"}, dat,      exp_data[k]);
        chk({tag, "_len"},  len,      64'(exp_len[k]));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(0, "d8m", 64'(d8m_data), 64'(d8m_len), d8m_val);
            mon_one(1, "d8l", 64'(d8l_data), 64'(d8l_len), d8l_val);
            mon_one(2, "d24", 64'(d24_data), 64'(d24_len), d24_val);
            if (d24_val) d24_pulses++;
        end
    end

    logic [7:0] pat8;
    logic [3:0] pat4;
    logic [7:0] e_len1 [4];
    int         p0;
    int         wlen;
    logic       lst;

    initial begin
        arst_n = 1'b0; sv = 1'b0; sd = 1'b0; sl = 1'b0;
        model_clear();
        #1;
        mon_en = 1'b1;
        do_reset();

        // Full 8-bit word, both bit orders at once
        pat8 = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) cyc(1'b1, pat8[i], 1'b0);
        chk("w8_msb_val",  64'(d8m_val),  64'd1);
        chk("w8_msb_data", 64'(d8m_data), 64'hB2);
        chk("w8_msb_len",  64'(d8m_len),  64'd8);
        chk("w8_lsb_data", 64'(d8l_data), 64'h4D);
        chk("w8_lsb_len",  64'(d8l_len),  64'd8);
        cyc(1'b0, 1'b1, 1'b1);
        chk("hold_val",  64'(d8m_val),  64'd0);
        chk("hold_data", 64'(d8m_data), 64'hB2);

        // Early last, then a back-to-back full word
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("short_data", 64'(d8m_data), 64'hE0);
        chk("short_len",  64'(d8m_len),  64'd3);
        chk("short_lsb",  64'(d8l_data), 64'h07);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
        chk("b2b_data", 64'(d8m_data), 64'hFF);
        chk("b2b_len",  64'(d8m_len),  64'd8);
        chk("b2b_val",  64'(d8m_val),  64'd1);

        // Last on the 8th bit closes exactly once
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i == 7) ? 1'b1 : 1'b0);
        chk("last8_len", 64'(d8m_len), 64'd8);
        cyc(1'b0, 1'b0, 1'b0);
        chk("last8_once", 64'(d8m_val), 64'd0);

        // Single-bit words every cycle
        do_reset();
        pat4 = 4'b1011;
        e_len1[0] = 8'h80; e_len1[1] = 8'h00; e_len1[2] = 8'h80; e_len1[3] = 8'h80;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, pat4[3 - i], 1'b1);
            chk("len1_val",  64'(d8m_val),  64'd1);
            chk("len1_data", 64'(d8m_data), 64'(e_len1[i]));
            chk("len1_len",  64'(d8m_len),  64'd1);
        end

        // Reset mid-word discards the partial word
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom), 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
        chk("rstmid_data", 64'(d8m_data), 64'hFF);
        chk("rstmid_len",  64'(d8m_len),  64'd8);

        // Random words with random gaps; ignored inputs are randomized during gaps
        do_reset();
        p0 = d24_pulses;
        for (int w = 0; w < 1000; w++) begin
            wlen = int'($urandom_range(1, 24));
            for (int i = 0; i < wlen; i++) begin
                repeat ($urandom_range(0, 5)) cyc(1'b0, 1'($urandom), 1'($urandom));
                if (i == wlen - 1) lst = (wlen == 24) ? 1'($urandom) : 1'b1;
                else               lst = 1'b0;
                cyc(1'b1, 1'($urandom), lst);
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("d24_word_count", 64'(d24_pulses - p0), 64'd1000);
        chk("d24_len_lo", 64'(d24_len_lo), 64'(exp_len[2] % 32));

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bit_stream_deserializer.md
Name: bit_stream_deserializer

Overview:
- Collects a serial, valid-qualified bit stream into WIDTH-bit parallel words.
- Sits directly upstream of the bit population counter; its data_o/data_val_o drive that block's data_i/data_val_i.
- A word is emitted when WIDTH bits have been collected, or early when the sender marks a bit as last. A partial word is zero-padded, so the downstream popcount is unaffected by the padding.

Parameters:
- WIDTH, 24, output word width in bits; legal range 2..64, must match the downstream counter.
- MSB_FIRST, 1, 1: first received bit lands in data_o[WIDTH-1]; 0: first received bit lands in data_o[0].

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- arst_n_i  input  1  asynchronous active-low reset.
- ser_data_i  input  1  serial data bit.
- ser_data_val_i  input  1  ser_data_i and ser_last_i are valid this cycle.
- ser_last_i  input  1  current bit is the final bit of the word; qualified by ser_data_val_i.
- data_o  output  WIDTH  assembled word.
- data_len_o  output  $clog2(WIDTH)+1  number of valid bits in data_o, 1..WIDTH.
- data_val_o  output  1  one-cycle pulse; data_o and data_len_o are valid.

Behaviour:
- Reset (arst_n_i low, asynchronous assert, synchronous-safe deassert):
  - data_o = 0, data_len_o = 0, data_val_o = 0.
  - Bit counter = 0; shift/collect register cleared.
- State:
  - Bit counter cnt, range 0..WIDTH-1.
  - Collect register col[WIDTH-1:0].
  - Two implicit states. IDLE: cnt==0. COLLECT: cnt>0.
- Accepted bit (ser_data_val_i=1):
  - The bit is written to position WIDTH-1-cnt if MSB_FIRST=1, else to position cnt.
  - Word completes if cnt==WIDTH-1 or ser_last_i==1.
- On completion, at the next edge:
  - data_o <= col including the new bit; unfilled positions are 0.
  - data_len_o <= cnt+1.
  - data_val_o <= 1.
  - cnt <= 0; col <= 0.
- No completion: cnt <= cnt+1; outputs unchanged; data_val_o <= 0.
- ser_data_val_i=0: no state change. ser_data_i and ser_last_i are ignored. data_val_o <= 0. Gaps of any length mid-word are allowed.
- Latency: data_val_o asserts exactly 1 cycle after the cycle that accepted the completing bit.
- data_o and data_len_o hold their last values between pulses; they change only together with a data_val_o pulse.
- Back-to-back words: a bit accepted in the cycle after a completion starts a new word at cnt=0. Full throughput is one bit per cycle, with no dead cycles. data_val_o may pulse every cycle when ser_last_i=1 on every bit (len=1 words).
- ser_last_i on the WIDTH-th bit: single completion, len=WIDTH. Not counted twice.
- No backpressure: the downstream stage always accepts, so there is no ready signal and no overflow condition.
- Reset mid-word: the partial word is discarded and never emitted. The first valid bit after reset starts a fresh word.
- Width rules:
  - cnt is $clog2(WIDTH) bits.
  - data_len_o is one bit wider so that the value WIDTH is representable (e.g. WIDTH=24 -> 6 bits, max 24).

Test Plan:
- WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, last=0 -> one pulse 1 cycle after 8th bit: data_o=8'hB2, len=8.
- WIDTH=8, MSB_FIRST=0, same bit sequence -> data_o=8'h4D, len=8.
- WIDTH=8, MSB_FIRST=1, bits 1,1,1 with last on 3rd -> data_o=8'hE0, len=3. A following 8-bit word 8'hFF is accepted with no gap and emitted correctly (len=8).
- WIDTH=24, random valid gaps (val low 0–5 cycles between bits), 1000 random words of random length 1..24 -> every pulse matches a reference model (data, len). Exactly one pulse per word, no spurious pulses.
- Reset asserted after 5 of 8 bits, then 8 new bits 0xFF -> no pulse for the partial word; single pulse data_o=8'hFF, len=8. All outputs are 0 while reset is low.
- last=1 on every valid bit for 4 consecutive cycles, bits 1,0,1,1 -> 4 consecutive pulses, len=1 each, data_o = 8'h80, 8'h00, 8'h80, 8'h80 (MSB_FIRST=1).
